// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage RV32I pipeline: data-memory wait, EX redirect, load-use.
// Optional cycle counters are built when HAZ_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_rs1,
    input  logic [4:0]  ID_rs2,
    input  logic        ID_useRs1,
    input  logic        ID_useRs2,
    input  logic        EX_memRead,
    input  logic [4:0]  EX_rd,
    input  logic        EX_redirect,
    input  logic        MEM_memRead,
    input  logic        MEM_memWrite,
    input  logic        dmem_ready,
    input  logic        fault_clr,
    output logic        pc_en,
    output logic        pc_sel_redirect,
    output logic        IF_ID_en,
    output logic        ID_EX_en,
    output logic        EX_MEM_en,
    output logic        MEM_WB_en,
    output logic        IF_ID_flush,
    output logic        ID_EX_flush,
    output logic        EX_MEM_flush,
    output logic        MEM_WB_flush,
    output logic        dmem_req,
`ifdef HAZ_PERF_EN
    output logic [31:0] perf_loaduse,
    output logic [31:0] perf_memwait,
    output logic [31:0] perf_redirect,
`endif
    output logic        mem_fault
);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;

    logic acc, lu;
    logic stall, resolve, timeout;

    assign acc = MEM_memRead | MEM_memWrite;
    assign lu  = EX_memRead && (EX_rd != 5'd0) &&
                 ((ID_useRs1 && (ID_rs1 == EX_rd)) || (ID_useRs2 && (ID_rs2 == EX_rd)));

    assign mem_fault = fault_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        fault_d         = fault_q & ~fault_clr;
        stall           = 1'b0;
        resolve         = 1'b0;
        timeout         = 1'b0;
        pc_en           = 1'b1;
        pc_sel_redirect = 1'b0;
        IF_ID_en        = 1'b1;
        ID_EX_en        = 1'b1;
        EX_MEM_en       = 1'b1;
        MEM_WB_en       = 1'b1;
        IF_ID_flush     = 1'b0;
        ID_EX_flush     = 1'b0;
        EX_MEM_flush    = 1'b0;
        MEM_WB_flush    = 1'b0;
        dmem_req        = 1'b0;

        case (state_q)
            RUN: begin
                dmem_req = acc;
                if (acc && !dmem_ready) begin
                    stall   = 1'b1;
                    state_d = MEM_WAIT;
                    cnt_d   = '0;
                end else begin
                    resolve = 1'b1;
                end
            end
            MEM_WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    resolve = 1'b1;
                    state_d = RUN;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    resolve = 1'b1;
                    timeout = 1'b1;
                    state_d = RUN;
                    fault_d = 1'b1;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        // EX is frozen during a stall, so a pending redirect is simply re-presented later
        if (stall) begin
            pc_en        = 1'b0;
            IF_ID_en     = 1'b0;
            ID_EX_en     = 1'b0;
            EX_MEM_en    = 1'b0;
            MEM_WB_flush = 1'b1;
        end else if (resolve) begin
            if (EX_redirect) begin
                pc_sel_redirect = 1'b1;
                IF_ID_flush     = 1'b1;
                ID_EX_flush     = 1'b1;
            end else if (lu) begin
                pc_en       = 1'b0;
                IF_ID_en    = 1'b0;
                ID_EX_flush = 1'b1;
            end
            MEM_WB_flush = timeout;
        end

        if (rst) begin
            pc_en           = 1'b0;
            pc_sel_redirect = 1'b0;
            IF_ID_en        = 1'b0;
            ID_EX_en        = 1'b0;
            EX_MEM_en       = 1'b0;
            MEM_WB_en       = 1'b0;
            IF_ID_flush     = 1'b1;
            ID_EX_flush     = 1'b1;
            EX_MEM_flush    = 1'b1;
            MEM_WB_flush    = 1'b1;
            dmem_req        = 1'b0;
        end
    end

`ifdef HAZ_PERF_EN
    logic hit_loaduse, hit_redirect;
    assign hit_redirect = resolve & EX_redirect;
    assign hit_loaduse  = resolve & ~EX_redirect & lu;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_loaduse  <= '0;
            perf_memwait  <= '0;
            perf_redirect <= '0;
        end else begin
            if (hit_loaduse && (perf_loaduse != 32'hFFFF_FFFF))
                perf_loaduse <= perf_loaduse + 32'd1;
            if (stall && (perf_memwait != 32'hFFFF_FFFF))
                perf_memwait <= perf_memwait + 32'd1;
            if (hit_redirect && (perf_redirect != 32'hFFFF_FFFF))
                perf_redirect <= perf_redirect + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (TIMEOUT_CYCLES=4): vector table in RUN plus wait/timeout/reset sequences.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] ID_rs1, ID_rs2, EX_rd;
    logic ID_useRs1, ID_useRs2, EX_memRead, EX_redirect;
    logic MEM_memRead, MEM_memWrite, dmem_ready, fault_clr;
    logic pc_en, pc_sel_redirect, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en;
    logic IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, dmem_req, mem_fault;
`ifdef HAZ_PERF_EN
    logic [31:0] perf_loaduse, perf_memwait, perf_redirect;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_useRs1(ID_useRs1), .ID_useRs2(ID_useRs2),
        .EX_memRead(EX_memRead), .EX_rd(EX_rd), .EX_redirect(EX_redirect),
        .MEM_memRead(MEM_memRead), .MEM_memWrite(MEM_memWrite),
        .dmem_ready(dmem_ready), .fault_clr(fault_clr),
        .pc_en(pc_en), .pc_sel_redirect(pc_sel_redirect),
        .IF_ID_en(IF_ID_en), .ID_EX_en(ID_EX_en), .EX_MEM_en(EX_MEM_en), .MEM_WB_en(MEM_WB_en),
        .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
        .EX_MEM_flush(EX_MEM_flush), .MEM_WB_flush(MEM_WB_flush),
        .dmem_req(dmem_req),
`ifdef HAZ_PERF_EN
        .perf_loaduse(perf_loaduse), .perf_memwait(perf_memwait), .perf_redirect(perf_redirect),
`endif
        .mem_fault(mem_fault)
    );

    // {pc_en, pc_sel, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en, IF_ID_fl, ID_EX_fl, EX_MEM_fl, MEM_WB_fl, dmem_req}
    logic [10:0] outs;
    assign outs = {pc_en, pc_sel_redirect, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
                   IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, dmem_req};

    localparam logic [10:0] O_RESET = 11'b0_0_0000_1111_0;
    localparam logic [10:0] O_NORM  = 11'b1_0_1111_0000_0;
    localparam logic [10:0] O_LU    = 11'b0_0_0111_0100_0;
    localparam logic [10:0] O_REDIR = 11'b1_1_1111_1100_0;
    localparam logic [10:0] O_STALL = 11'b0_0_0001_0001_1;
    localparam logic [10:0] O_DROP  = 11'b1_0_1111_0001_1;
    localparam logic [10:0] REQ     = 11'b0_0_0000_0000_1;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use1;
        logic        use2;
        logic        ex_mr;
        logic [4:0]  ex_rd;
        logic        redir;
        logic        mr;
        logic        mw;
        logic        rdy;
        logic [10:0] exp_o;
    } vec_t;

    vec_t tbl [12];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        n_checks++;
        if (got === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp_v);
    endtask

    task automatic clr_in();
        ID_rs1 = 0; ID_rs2 = 0; ID_useRs1 = 0; ID_useRs2 = 0;
        EX_memRead = 0; EX_rd = 0; EX_redirect = 0;
        MEM_memRead = 0; MEM_memWrite = 0; dmem_ready = 0; fault_clr = 0;
    endtask

    task automatic drive(input vec_t v);
        ID_rs1 = v.rs1; ID_rs2 = v.rs2; ID_useRs1 = v.use1; ID_useRs2 = v.use2;
        EX_memRead = v.ex_mr; EX_rd = v.ex_rd; EX_redirect = v.redir;
        MEM_memRead = v.mr; MEM_memWrite = v.mw; dmem_ready = v.rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
    endtask

    task automatic step_chk(input string name, input logic [10:0] exp_o);
        #2;
        chk(name, 32'(outs), 32'(exp_o));
        tick();
    endtask

    // Drive an access whose ready never comes before the 4th wait cycle; optionally ready exactly then.
    task automatic timeout_seq(input logic clr, input logic rdy_at_end, input string tag);
        clr_in();
        MEM_memRead = 1; fault_clr = clr;
        step_chk({tag, "_enter"}, O_STALL);
        for (int i = 0; i < 3; i++) step_chk($sformatf("%s_wait%0d", tag, i), O_STALL);
        dmem_ready = rdy_at_end;
        #2;
        chk({tag, "_last_outs"}, 32'(outs), 32'(rdy_at_end ? (O_NORM | REQ) : O_DROP));
        chk({tag, "_last_fault"}, 32'(mem_fault), 32'd0);
        tick();
        clr_in();
        #2;
        chk({tag, "_fault"}, 32'(mem_fault), 32'(!rdy_at_end));
        chk({tag, "_run"}, 32'(outs), 32'(O_NORM));
        tick();
        fault_clr = 1;
        tick();
        fault_clr = 0;
        #2;
        chk({tag, "_cleared"}, 32'(mem_fault), 32'd0);
        tick();
    endtask

    initial begin
        //          rs1 rs2 u1 u2 exmr exrd rd mr mw rdy exp
        tbl[0]  = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, O_NORM};
        tbl[1]  = '{5'd1, 5'd5, 0, 1, 1, 5'd5, 0, 0, 0, 0, O_LU};
        tbl[2]  = '{5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 0, 0, 0, O_NORM};
        tbl[3]  = '{5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 0, 0, O_NORM};
        tbl[4]  = '{5'd7, 5'd3, 1, 0, 1, 5'd7, 0, 0, 0, 0, O_LU};
        tbl[5]  = '{5'd7, 5'd3, 0, 1, 1, 5'd7, 0, 0, 0, 0, O_NORM};
        tbl[6]  = '{5'd7, 5'd7, 1, 1, 0, 5'd7, 0, 0, 0, 0, O_NORM};
        tbl[7]  = '{5'd9, 5'd0, 1, 0, 1, 5'd9, 1, 0, 0, 0, O_REDIR};
        tbl[8]  = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, 1, O_REDIR};
        tbl[9]  = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 1, O_NORM | REQ};
        tbl[10] = '{5'd31, 5'd0, 1, 0, 1, 5'd31, 0, 0, 1, 1, O_LU | REQ};
        tbl[11] = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 1, 1, O_REDIR | REQ};

        clr_in();
        rst = 1'b1;
        #2;
        chk("reset_outs", 32'(outs), 32'(O_RESET));
        chk("reset_fault", 32'(mem_fault), 32'd0);
        #10;
        rst = 1'b0;
        tick();

        foreach (tbl[i]) begin
            drive(tbl[i]);
            step_chk($sformatf("vec%0d", i), tbl[i].exp_o);
        end
        clr_in();
        step_chk("after_zero_wait_run", O_NORM);
`ifdef HAZ_PERF_EN
        chk("perf_loaduse", perf_loaduse, 32'd3);
        chk("perf_redirect", perf_redirect, 32'd3);
`endif

        // three stalled cycles on a store, ready on the fourth
        do_reset();
        tick();
        MEM_memWrite = 1;
        step_chk("w3_run", O_STALL);
        step_chk("w3_wait0", O_STALL);
        step_chk("w3_wait1", O_STALL);
        dmem_ready = 1;
        step_chk("w3_ready", O_NORM | REQ);
        clr_in();
        step_chk("w3_back_run", O_NORM);
`ifdef HAZ_PERF_EN
        chk("perf_memwait", perf_memwait, 32'd3);
`endif

        // redirect held while the load waits
        MEM_memRead = 1; EX_redirect = 1;
        step_chk("rw_run", O_STALL);
        step_chk("rw_wait", O_STALL);
        dmem_ready = 1;
        step_chk("rw_ready", O_REDIR | REQ);
        clr_in();
        step_chk("rw_back_run", O_NORM);

        // load-use resolved on the completion cycle of a wait
        MEM_memRead = 1; EX_memRead = 1; EX_rd = 5'd4; ID_rs1 = 5'd4; ID_useRs1 = 1;
        step_chk("lw_run", O_STALL);
        dmem_ready = 1;
        step_chk("lw_ready", O_LU | REQ);
        clr_in();

        timeout_seq(1'b0, 1'b0, "to");
        timeout_seq(1'b1, 1'b0, "to_setwins");
        timeout_seq(1'b0, 1'b1, "to_readywins");

        // reset arriving in the middle of a wait
        MEM_memRead = 1;
        step_chk("rm_run", O_STALL);
        #1;
        chk("rm_wait_req", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rm_async_outs", 32'(outs), 32'(O_RESET));
        #3;
        rst = 1'b0;
        MEM_memRead = 0;
        #1;
        chk("rm_state_run", 32'(outs), 32'(O_NORM));
        tick();
        step_chk("rm_next", O_NORM);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
